// File: rtl/dual_rail_tx.sv
// Clocked-to-delay-insensitive boundary stage: single-rail valid/ready words in,
// dual-rail tokens out (four-phase RTZ or two-phase transition), completed on a synchronised ack.
module dual_rail_tx #(
  parameter int WIDTH    = 3,
  parameter int RAIL_NUM = 2,
  parameter     ENC      = "FP",
  parameter int TIMEOUT  = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
  input  logic                               ack,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam bit IS_TP = (ENC == "TP");
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    NULL_S = 2'd2
  } state_t;

  state_t                           state_q;
  logic [WIDTH-1:0][RAIL_NUM-1:0]   out_q;
  logic [1:0]                       ack_sync_q;
  logic                             phase_q;
  logic                             rdy_en_q;
  logic                             err_q;
  logic [CW-1:0]                    cnt_q;
  logic [CW-1:0]                    cnt_d;
  logic                             to_hit;
  logic                             ack_s;
  logic                             accept;

  assign ack_s = ack_sync_q[1];

  // rdy_en_q keeps in_ready low while reset is asserted, since IDLE alone would allow it
  assign in_ready    = rdy_en_q && (state_q == IDLE) && (IS_TP || !ack_s);
  assign busy        = (state_q != IDLE);
  assign out         = out_q;
  assign timeout_err = err_q;
  assign accept      = in_valid && in_ready;

  always_comb begin
    cnt_d  = (cnt_q == TO_LAST) ? cnt_q : cnt_q + 1'b1;
    to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      out_q      <= '0;
      ack_sync_q <= '0;
      phase_q    <= 1'b0;
      rdy_en_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      ack_sync_q <= {ack_sync_q[0], ack};
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= DATA;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
              if (IS_TP) begin
                if (in_data[i]) out_q[i][1] <= ~out_q[i][1];
                else            out_q[i][0] <= ~out_q[i][0];
              end else begin
                out_q[i] <= in_data[i] ? 2'b10 : 2'b01;
              end
            end
          end
        end
        DATA: begin
          if (IS_TP && (ack_s != phase_q)) begin
            phase_q <= ~phase_q;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (!IS_TP && ack_s) begin
            state_q <= NULL_S;
            out_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (to_hit) err_q <= 1'b1;
          end
        end
        NULL_S: begin
          if (!ack_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (to_hit) err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dual_rail_tx.sv
// Directed bench for dual_rail_tx: FP instance with completion-detector ack feeding a
// full-adder decode, plus a WIDTH=1 TP instance with a parity (transition) ack.
module tb_dual_rail_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // FP instance, 3 bits, TIMEOUT=16
  logic             fp_valid = 1'b0;
  logic             fp_ready;
  logic [2:0]       fp_data  = '0;
  logic [2:0][1:0]  fp_out;
  logic             fp_ack;
  logic             fp_busy;
  logic             fp_err;
  logic [1:0]       ack_mode = 2'd0;   // 0: completion model, 1: forced 0, 2: forced 1
  logic             fp_cmpl;

  always_comb begin
    fp_cmpl = 1'b1;
    for (int i = 0; i < 3; i++) fp_cmpl = fp_cmpl & (fp_out[i][1] | fp_out[i][0]);
  end
  assign fp_ack = (ack_mode == 2'd0) ? fp_cmpl : (ack_mode == 2'd2);

  dual_rail_tx #(.WIDTH(3), .RAIL_NUM(2), .ENC("FP"), .TIMEOUT(16)) u_fp (
    .clk(clk), .rst(rst), .in_valid(fp_valid), .in_ready(fp_ready), .in_data(fp_data),
    .out(fp_out), .ack(fp_ack), .busy(fp_busy), .timeout_err(fp_err)
  );

  // TP instance, 1 bit
  logic             tp_valid = 1'b0;
  logic             tp_ready;
  logic [0:0]       tp_data  = '0;
  logic [0:0][1:0]  tp_out;
  logic             tp_ack;
  logic             tp_busy;
  logic             tp_err;

  assign tp_ack = tp_out[0][1] ^ tp_out[0][0];

  dual_rail_tx #(.WIDTH(1), .RAIL_NUM(2), .ENC("TP"), .TIMEOUT(1024)) u_tp (
    .clk(clk), .rst(rst), .in_valid(tp_valid), .in_ready(tp_ready), .in_data(tp_data),
    .out(tp_out), .ack(tp_ack), .busy(tp_busy), .timeout_err(tp_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0] sb_cw  [$];
  logic [1:0] sb_sum [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] codeword(input logic [2:0] w);
    logic [5:0] r;
    for (int i = 0; i < 3; i++) r[i*2 +: 2] = w[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic push(input logic [2:0] w, input logic [1:0] s);
    sb_cw.push_back(codeword(w));
    sb_sum.push_back(s);
  endtask

  task automatic pop_check();
    logic [5:0] cw;
    logic [1:0] s;
    logic [1:0] adder;
    chk("sb_nonempty", (sb_cw.size() > 0), 1);
    if (sb_cw.size() > 0) begin
      cw = sb_cw.pop_front();
      s  = sb_sum.pop_front();
      adder = {1'b0, fp_out[0][1]} + {1'b0, fp_out[1][1]} + {1'b0, fp_out[2][1]};
      chk("fp_codeword", fp_out, cw);
      chk("adder_sum", adder, s);
    end
  endtask

  task automatic wait_fp_ready();
    int n = 0;
    while (!fp_ready && n < 40) begin
      tick();
      n++;
    end
    chk("fp_ready_wait", fp_ready, 1);
  endtask

  logic [2:0] words [4];
  logic [1:0] sums  [4];

  initial begin
    words = '{3'b000, 3'b001, 3'b111, 3'b101};
    sums  = '{2'b00, 2'b01, 2'b11, 2'b10};

    // 1: reset with in_valid high
    fp_valid = 1'b1;
    fp_data  = 3'b011;
    #2 rst = 1'b0;
    #20;
    chk("rst_out", fp_out, 0);
    chk("rst_ready", fp_ready, 0);
    chk("rst_busy", fp_busy, 0);
    chk("rst_err", fp_err, 0);
    chk("rst_tp_ready", tp_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rel_ready", fp_ready, 1);

    // 2: FP 011, zero-delay ack, 7-cycle period
    push(3'b011, 2'b10);
    tick();
    pop_check();
    chk("data_busy", fp_busy, 1);
    chk("data_ready", fp_ready, 0);
    repeat (3) tick();
    chk("null_out", fp_out, 0);
    repeat (2) tick();
    chk("ready_early", fp_ready, 0);
    tick();
    chk("ready_at6", fp_ready, 1);
    chk("idle_busy", fp_busy, 0);
    push(3'b011, 2'b10);
    tick();
    pop_check();
    fp_valid = 1'b0;

    // 3: adder stream, in_valid held
    for (int k = 0; k < 4; k++) begin
      fp_data  = words[k];
      fp_valid = 1'b1;
      wait_fp_ready();
      push(words[k], sums[k]);
      tick();
      pop_check();
      repeat (3) tick();
      chk("stream_null", fp_out, 0);
    end
    fp_valid = 1'b0;

    // 4: timeout with ack held low
    ack_mode = 2'd1;
    fp_data  = 3'b101;
    fp_valid = 1'b1;
    wait_fp_ready();
    push(3'b101, 2'b10);
    tick();
    pop_check();
    fp_valid = 1'b0;
    repeat (15) tick();
    chk("err_before", fp_err, 0);
    tick();
    chk("err_set", fp_err, 1);
    chk("err_hold_cw", fp_out, codeword(3'b101));
    ack_mode = 2'd0;
    for (int n = 0; n < 20 && fp_busy; n++) tick();
    chk("to_complete", fp_busy, 0);
    chk("err_sticky", fp_err, 1);

    // 6: reset mid-DATA
    fp_data  = 3'b110;
    fp_valid = 1'b1;
    wait_fp_ready();
    tick();
    fp_valid = 1'b0;
    chk("mid_busy", fp_busy, 1);
    #3 rst = 1'b0;
    #1;
    chk("async_out", fp_out, 0);
    chk("async_busy", fp_busy, 0);
    chk("async_err", fp_err, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", fp_ready, 1);
    repeat (5) tick();
    chk("no_replay_out", fp_out, 0);
    chk("no_replay_busy", fp_busy, 0);

    // 5: TP, words 1,1,0
    chk("tp_ready0", tp_ready, 1);
    chk("tp_out0", tp_out, 0);
    tp_data  = 1'b1;
    tp_valid = 1'b1;
    tick();
    chk("tp_tok1", tp_out, 2'b10);
    chk("tp_busy", tp_busy, 1);
    chk("tp_ready_busy", tp_ready, 0);
    repeat (2) tick();
    chk("tp_ready_early", tp_ready, 0);
    tick();
    chk("tp_ready_at3", tp_ready, 1);
    tick();
    chk("tp_tok2", tp_out, 2'b00);
    tp_data = 1'b0;
    repeat (4) tick();
    chk("tp_tok3", tp_out, 2'b01);
    tp_valid = 1'b0;
    repeat (4) tick();
    chk("tp_idle", tp_busy, 0);
    chk("tp_err", tp_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
